multicycle_controller: RTL and testbench

Sequencing control unit for the multi-cycle variant of the core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath select and enable. That includes `imm_src` for the immediate extender, `alu_control`, and the PC, IR, register-file and memory write enables. A `mem_ready` handshake on the shared instruction/data memory lets the core tolerate multi-cycle memory.

---
 rtl/riscv_mc_pkg.sv | 49 ++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 133 +++++++++++++
 tb/tb_multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared states, opcodes and control codes for the multi-cycle core
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op and instruction function fields to alu_control
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects sub for register-register ops; addi reuses that bit as immediate
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle sequencing FSM; MC_BNE_EN adds bne support
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       illegal_instr
);

  state_t     state, next_state;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          default: begin
            illegal_instr = 1'b1;
            next_state    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        if (funct3 == 3'b000) pc_write = zero;
`ifdef MC_BNE_EN
        else if (funct3 == 3'b001) pc_write = ~zero;
`endif
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign imm_src = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed checks of the multi-cycle controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .imm_src       (imm_src),
    .illegal_instr (illegal_instr)
  );

  // {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr, result_src, alu_src_a, alu_src_b, alu_control}
  logic [14:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
                 result_src, alu_src_a, alu_src_b, alu_control};

  localparam logic [14:0] E_FETCH_RDY  = 15'b100100_10_00_10_000;
  localparam logic [14:0] E_FETCH_NRDY = 15'b000000_10_00_10_000;
  localparam logic [14:0] E_DECODE     = 15'b000000_00_01_01_000;
  localparam logic [14:0] E_DECODE_ILL = 15'b000001_00_01_01_000;
  localparam logic [14:0] E_MEMADR     = 15'b000000_00_10_01_000;
  localparam logic [14:0] E_MEMREAD    = 15'b010000_00_00_00_000;
  localparam logic [14:0] E_MEMWB      = 15'b000010_01_00_00_000;
  localparam logic [14:0] E_MEMWRITE   = 15'b011000_00_00_00_000;
  localparam logic [14:0] E_EXEC_SUB   = 15'b000000_00_10_00_001;
  localparam logic [14:0] E_EXECI_ADD  = 15'b000000_00_10_01_000;
  localparam logic [14:0] E_ALUWB      = 15'b000010_00_00_00_000;
  localparam logic [14:0] E_BR_TAKEN   = 15'b100000_00_10_00_001;
  localparam logic [14:0] E_BR_NOT     = 15'b000000_00_10_00_001;
  localparam logic [14:0] E_JAL        = 15'b100000_00_01_10_000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH just after reset release, ahead of the next rising edge.
  task automatic start_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    reset = 1'b1;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #1;
    n_checks++;
    if (outs !== E_FETCH_RDY) begin
      n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, E_FETCH_RDY);
    end
    tick; tick;
    n_checks++;
    if (outs !== E_FETCH_RDY) begin
      n_fail++; $display("FAIL reset_held: got %b expected %b", outs, E_FETCH_RDY);
    end
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== E_FETCH_NRDY) begin
      n_fail++; $display("FAIL reset_nrdy: got %b expected %b", outs, E_FETCH_NRDY);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick;
    n_checks++;
    if (outs !== E_DECODE) begin
      n_fail++; $display("FAIL reset_release_decode: got %b expected %b", outs, E_DECODE);
    end
  endtask

  task automatic test_lw;
    logic [14:0] exp_seq [6];
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_FETCH_RDY};
    start_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (outs !== exp_seq[i] || imm_src !== 2'b00) begin
        n_fail++;
        $display("FAIL lw cycle %0d: got %b imm %b expected %b imm 00", i, outs, imm_src, exp_seq[i]);
      end
      if (i < 5) tick;
    end
  endtask

  task automatic test_lw_stall;
    start_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick; tick; mem_ready = 1'b0; tick;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (outs !== E_MEMREAD) begin
        n_fail++; $display("FAIL lw_stall memread %0d: got %b expected %b", i, outs, E_MEMREAD);
      end
      tick;
    end
    mem_ready = 1'b1;
    tick;
    n_checks++;
    if (outs !== E_MEMWB) begin
      n_fail++; $display("FAIL lw_stall memwb: got %b expected %b", outs, E_MEMWB);
    end
  endtask

  task automatic test_sw_wait;
    int mw_cycles = 0;
    start_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    n_checks++;
    if (imm_src !== 2'b01) begin
      n_fail++; $display("FAIL sw_imm_src: got %b expected 01", imm_src);
    end
    tick; tick;
    n_checks++;
    if (outs !== E_MEMADR) begin
      n_fail++; $display("FAIL sw_memadr: got %b expected %b", outs, E_MEMADR);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      n_checks++;
      if (outs !== E_MEMWRITE) begin
        n_fail++; $display("FAIL sw_memwrite %0d: got %b expected %b", i, outs, E_MEMWRITE);
      end
      if (mem_write === 1'b1) mw_cycles++;
    end
    tick;
    n_checks++;
    if (mw_cycles != 4 || outs !== E_FETCH_RDY) begin
      n_fail++; $display("FAIL sw_done: got %0d writes outs %b expected 4 writes outs %b", mw_cycles, outs, E_FETCH_RDY);
    end
  endtask

  task automatic test_rtype_itype;
    logic [14:0] exp_seq [5];
    exp_seq = '{E_FETCH_NRDY, E_DECODE, E_EXEC_SUB, E_ALUWB, E_FETCH_RDY};
    start_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (outs !== E_FETCH_NRDY) begin
      n_fail++; $display("FAIL rtype_fetch_stall: got %b expected %b", outs, E_FETCH_NRDY);
    end
    tick;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs !== E_FETCH_RDY) begin
      n_fail++; $display("FAIL rtype_fetch_ready: got %b expected %b", outs, E_FETCH_RDY);
    end
    for (int i = 1; i < 5; i++) begin
      tick;
      n_checks++;
      if (outs !== exp_seq[i]) begin
        n_fail++; $display("FAIL rtype_sub cycle %0d: got %b expected %b", i, outs, exp_seq[i]);
      end
    end
    start_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    tick; tick;
    n_checks++;
    if (outs !== E_EXECI_ADD) begin
      n_fail++; $display("FAIL itype_addi: got %b expected %b", outs, E_EXECI_ADD);
    end
  endtask

  task automatic test_funct_decode;
    logic [2:0] f3_tab  [4];
    logic [2:0] exp_tab [4];
    f3_tab  = '{3'b010, 3'b110, 3'b111, 3'b100};
    exp_tab = '{3'b101, 3'b011, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) begin
      start_instr(7'b0110011, f3_tab[i], 1'b0, 1'b0);
      tick; tick;
      n_checks++;
      if (alu_control !== exp_tab[i]) begin
        n_fail++; $display("FAIL funct_decode f3=%b: got %b expected %b", f3_tab[i], alu_control, exp_tab[i]);
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0]  f3_tab  [4];
    logic        z_tab   [4];
    logic [14:0] exp_tab [4];
    f3_tab = '{3'b000, 3'b000, 3'b001, 3'b001};
    z_tab  = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MC_BNE_EN
    exp_tab = '{E_BR_TAKEN, E_BR_NOT, E_BR_TAKEN, E_BR_NOT};
`else
    exp_tab = '{E_BR_TAKEN, E_BR_NOT, E_BR_NOT, E_BR_NOT};
`endif
    for (int i = 0; i < 4; i++) begin
      start_instr(7'b1100011, f3_tab[i], 1'b0, z_tab[i]);
      tick; tick;
      n_checks++;
      if (outs !== exp_tab[i] || imm_src !== 2'b10) begin
        n_fail++;
        $display("FAIL branch f3=%b z=%b: got %b imm %b expected %b imm 10", f3_tab[i], z_tab[i], outs, imm_src, exp_tab[i]);
      end
      tick;
      n_checks++;
      if (outs !== E_FETCH_RDY) begin
        n_fail++; $display("FAIL branch_return %0d: got %b expected %b", i, outs, E_FETCH_RDY);
      end
    end
  endtask

  task automatic test_illegal_jal;
    logic [14:0] exp_seq [5];
    start_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    tick;
    n_checks++;
    if (outs !== E_DECODE_ILL) begin
      n_fail++; $display("FAIL illegal_decode: got %b expected %b", outs, E_DECODE_ILL);
    end
    tick;
    n_checks++;
    if (outs !== E_FETCH_RDY) begin
      n_fail++; $display("FAIL illegal_return: got %b expected %b", outs, E_FETCH_RDY);
    end
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_JAL, E_ALUWB, E_FETCH_RDY};
    start_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (outs !== exp_seq[i] || imm_src !== 2'b11) begin
        n_fail++;
        $display("FAIL jal cycle %0d: got %b imm %b expected %b imm 11", i, outs, imm_src, exp_seq[i]);
      end
      if (i < 4) tick;
    end
  endtask

  task automatic test_reset_midway;
    start_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    tick; tick;
    mem_ready = 1'b0;
    tick;
    n_checks++;
    if (outs !== E_MEMWRITE) begin
      n_fail++; $display("FAIL midway_memwrite: got %b expected %b", outs, E_MEMWRITE);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== E_FETCH_NRDY) begin
      n_fail++; $display("FAIL midway_reset: got %b expected %b", outs, E_FETCH_NRDY);
    end
    tick;
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lw_stall;
    test_sw_wait;
    test_rtype_itype;
    test_funct_decode;
    test_branch;
    test_illegal_jal;
    test_reset_midway;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
